// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared period counter (edge or center
// aligned), per-channel duty/enable/polarity, double-buffered configuration.
module pwm_multi #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [CNT_W-1:0]          period_in,
  input  logic [NUM_CH*CNT_W-1:0]   duty_in,
  input  logic [NUM_CH-1:0]         ch_en_in,
  input  logic [NUM_CH-1:0]         invert_in,
  input  logic                      center_in,
  input  logic                      load,
  output logic                      pending,
  output logic                      period_start,
  output logic [NUM_CH-1:0]         pwm
);

  localparam int unsigned DUTY_W = NUM_CH * CNT_W;
  localparam logic [0:0] DIR_UP   = 1'b0;
  localparam logic [0:0] DIR_DOWN = 1'b1;

  // shadow set (staged by load)
  logic [CNT_W-1:0]  per_s;
  logic [DUTY_W-1:0] duty_s;
  logic [NUM_CH-1:0] en_s;
  logic [NUM_CH-1:0] inv_s;
  logic              ctr_s;

  // active set (used by counter and compare)
  logic [CNT_W-1:0]  per_a;
  logic [DUTY_W-1:0] duty_a;
  logic [NUM_CH-1:0] en_a;
  logic [NUM_CH-1:0] inv_a;
  logic              ctr_a;

  logic [CNT_W-1:0]  ctr;
  logic [CNT_W-1:0]  ctr_nxt;
  logic [0:0]        dir;
  logic [0:0]        dir_nxt;
  logic [CNT_W-1:0]  last;
  logic              term;
  logic              commit;
  logic [NUM_CH-1:0] raw;

  // Counter sequencing, terminal-cycle detection and per-channel compare
  always_comb begin
    ctr_nxt = ctr;
    dir_nxt = dir;
    term    = 1'b0;
    raw     = '0;
    last    = (per_a == '0) ? '0 : per_a - CNT_W'(1);
    if (!ctr_a) begin
      if (ctr >= last) begin
        term    = 1'b1;
        ctr_nxt = '0;
      end else begin
        ctr_nxt = ctr + CNT_W'(1);
      end
    end else if (dir == DIR_UP) begin
      if (ctr >= last) dir_nxt = DIR_DOWN;
      else             ctr_nxt = ctr + CNT_W'(1);
    end else begin
      if (ctr == '0) begin
        term    = 1'b1;
        dir_nxt = DIR_UP;
      end else begin
        ctr_nxt = ctr - CNT_W'(1);
      end
    end
    commit = term & pending;
    // A commit always starts a fresh period, even across a mode change
    if (commit) begin
      ctr_nxt = '0;
      dir_nxt = DIR_UP;
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      raw[i] = en_a[i] & (ctr < duty_a[i*CNT_W +: CNT_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctr          <= '0;
      dir          <= DIR_UP;
      per_s        <= '0;
      duty_s       <= '0;
      en_s         <= '0;
      inv_s        <= '0;
      ctr_s        <= 1'b0;
      per_a        <= '0;
      duty_a       <= '0;
      en_a         <= '0;
      inv_a        <= '0;
      ctr_a        <= 1'b0;
      pending      <= 1'b0;
      period_start <= 1'b0;
      pwm          <= '0;
    end else begin
      ctr          <= ctr_nxt;
      dir          <= dir_nxt;
      period_start <= term;
      pwm          <= raw ^ inv_a;
      if (commit) begin
        per_a  <= per_s;
        duty_a <= duty_s;
        en_a   <= en_s;
        inv_a  <= inv_s;
        ctr_a  <= ctr_s;
      end
      // A load coinciding with a commit refills the shadow and keeps pending set
      if (load) begin
        per_s  <= period_in;
        duty_s <= duty_in;
        en_s   <= ch_en_in;
        inv_s  <= invert_in;
        ctr_s  <= center_in;
      end
      pending <= load | (pending & ~term);
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: period-position reference model checked every cycle,
// a table of steady-state duty vectors, and hand-written corner sequences.
module tb_pwm_multi;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 16;

  logic                     clk = 1'b0;
  logic                     resetn = 1'b0;
  logic [CNT_W-1:0]         period_in = '0;
  logic [NUM_CH*CNT_W-1:0]  duty_in = '0;
  logic [NUM_CH-1:0]        ch_en_in = '0;
  logic [NUM_CH-1:0]        invert_in = '0;
  logic                     center_in = 1'b0;
  logic                     load = 1'b0;
  logic                     pending;
  logic                     period_start;
  logic [NUM_CH-1:0]        pwm;

  pwm_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .period_in(period_in), .duty_in(duty_in),
    .ch_en_in(ch_en_in), .invert_in(invert_in), .center_in(center_in),
    .load(load), .pending(pending), .period_start(period_start), .pwm(pwm)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  // Reference model: position within the period rather than a counter/direction pair
  int                m_pos;
  int                m_per,  s_per;
  int                m_duty[NUM_CH];
  int                s_duty[NUM_CH];
  logic [NUM_CH-1:0] m_en, m_inv, s_en, s_inv;
  logic              m_center, s_center;
  logic              m_pend, m_ps;
  logic [NUM_CH-1:0] m_pwm;

  function automatic int m_len();
    int pe;
    pe = (m_per == 0) ? 1 : m_per;
    return m_center ? 2 * pe : pe;
  endfunction

  function automatic int m_ctr();
    int pe;
    pe = (m_per == 0) ? 1 : m_per;
    if (!m_center) return m_pos;
    return (m_pos < pe) ? m_pos : 2 * pe - 1 - m_pos;
  endfunction

  function automatic logic m_term();
    return m_pos == m_len() - 1;
  endfunction

  task automatic model_edge();
    int c;
    logic t;
    if (!resetn) begin
      m_pos = 0; m_per = 0; s_per = 0;
      m_en = '0; m_inv = '0; s_en = '0; s_inv = '0;
      m_center = 1'b0; s_center = 1'b0;
      m_pend = 1'b0; m_ps = 1'b0; m_pwm = '0;
      for (int i = 0; i < NUM_CH; i++) begin m_duty[i] = 0; s_duty[i] = 0; end
    end else begin
      c = m_ctr();
      t = m_term();
      for (int i = 0; i < NUM_CH; i++) m_pwm[i] = (m_en[i] && (c < m_duty[i])) ^ m_inv[i];
      m_ps = t;
      if (t) begin
        m_pos = 0;
        if (m_pend) begin
          m_per = s_per; m_en = s_en; m_inv = s_inv; m_center = s_center;
          for (int i = 0; i < NUM_CH; i++) m_duty[i] = s_duty[i];
        end
      end else begin
        m_pos++;
      end
      if (load) begin
        s_per = int'(period_in); s_en = ch_en_in; s_inv = invert_in; s_center = center_in;
        for (int i = 0; i < NUM_CH; i++) s_duty[i] = int'(duty_in[i*CNT_W +: CNT_W]);
        m_pend = 1'b1;
      end else if (t) begin
        m_pend = 1'b0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cycle, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cycle++;
    #1;
    check("model", 32'({pending, period_start, pwm}), 32'({m_pend, m_ps, m_pwm}));
  endtask

  task automatic do_reset();
    resetn = 1'b0; load = 1'b0;
    step(); step();
    resetn = 1'b1;
  endtask

  task automatic set_cfg(input int p, input int d0, input logic [NUM_CH-1:0] en,
                         input logic [NUM_CH-1:0] inv, input logic c);
    period_in = CNT_W'(p);
    duty_in   = '0;
    duty_in[CNT_W-1:0] = CNT_W'(d0);
    ch_en_in  = en;
    invert_in = inv;
    center_in = c;
  endtask

  task automatic do_load(input int p, input int d0, input logic [NUM_CH-1:0] en,
                         input logic [NUM_CH-1:0] inv, input logic c);
    set_cfg(p, d0, en, inv, c);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic wait_ps(input int max);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < max && !seen; k++) begin
      step();
      seen = period_start;
    end
    if (!seen) check("wait_period_start", 32'(seen), 32'd1);
  endtask

  typedef struct {
    int   p;
    int   d;
    logic en;
    logic inv;
    logic center;
    int   exp_len;
    int   exp_high;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int high, other, ps_cnt, ps_last;

    vecs[0] = '{p:10, d:3,  en:1'b1, inv:1'b0, center:1'b0, exp_len:10, exp_high:3};
    vecs[1] = '{p:10, d:0,  en:1'b1, inv:1'b0, center:1'b0, exp_len:10, exp_high:0};
    vecs[2] = '{p:10, d:10, en:1'b1, inv:1'b0, center:1'b0, exp_len:10, exp_high:10};
    vecs[3] = '{p:10, d:12, en:1'b1, inv:1'b0, center:1'b0, exp_len:10, exp_high:10};
    vecs[4] = '{p:10, d:5,  en:1'b0, inv:1'b1, center:1'b0, exp_len:10, exp_high:10};
    vecs[5] = '{p:8,  d:3,  en:1'b1, inv:1'b0, center:1'b1, exp_len:16, exp_high:6};
    vecs[6] = '{p:0,  d:1,  en:1'b1, inv:1'b0, center:1'b1, exp_len:2,  exp_high:2};
    vecs[7] = '{p:5,  d:2,  en:1'b1, inv:1'b1, center:1'b0, exp_len:5,  exp_high:3};

    do_reset();
    check("reset_outputs", 32'({pending, period_start, pwm}), 32'd0);

    // First load after reset: pending for exactly one cycle
    do_load(10, 3, 4'b0001, 4'b0000, 1'b0);
    check("pending_after_load", 32'(pending), 32'd1);
    step();
    check("pending_one_cycle", 32'(pending), 32'd0);

    // Steady-state duty table
    foreach (vecs[v]) begin
      do_reset();
      do_load(vecs[v].p, vecs[v].d, {3'b000, vecs[v].en}, {3'b000, vecs[v].inv}, vecs[v].center);
      wait_ps(100);
      wait_ps(100);
      high = 0; other = 0; ps_cnt = 0; ps_last = -1;
      for (int k = 1; k <= vecs[v].exp_len; k++) begin
        step();
        high += int'(pwm[0]);
        other += int'(pwm[NUM_CH-1:1] != '0);
        if (period_start) begin ps_cnt++; ps_last = k; end
      end
      check($sformatf("vec%0d_high", v), 32'(high), 32'(vecs[v].exp_high));
      check($sformatf("vec%0d_others", v), 32'(other), 32'd0);
      check($sformatf("vec%0d_period", v), 32'(ps_last), 32'(vecs[v].exp_len));
      check($sformatf("vec%0d_ps_count", v), 32'(ps_cnt), 32'd1);
    end

    // Mid-period reload at ctr=4: pending held until the boundary, then 7 high
    do_reset();
    do_load(10, 3, 4'b0001, 4'b0000, 1'b0);
    wait_ps(50);
    for (int k = 0; k < 20 && m_ctr() != 4; k++) step();
    do_load(10, 7, 4'b0001, 4'b0000, 1'b0);
    high = 0;
    for (int k = 0; k < 20 && !period_start; k++) begin
      check("reload_pending_held", 32'(pending), 32'd1);
      step();
    end
    check("reload_pending_cleared", 32'(pending), 32'd0);
    high = 0;
    for (int k = 0; k < 10; k++) begin step(); high += int'(pwm[0]); end
    check("reload_new_high", 32'(high), 32'd7);

    // Load coincident with commit: A committed while B enters the shadow
    do_reset();
    do_load(4, 1, 4'b0001, 4'b0000, 1'b0);
    do_load(6, 5, 4'b0001, 4'b0000, 1'b0);
    check("coinc_pending_kept", 32'(pending), 32'd1);
    high = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      high += int'(pwm[0]);
      check("coinc_pending_during_a", 32'(pending), 32'd1);
    end
    step();
    high += int'(pwm[0]);
    check("coinc_a_high", 32'(high), 32'd1);
    check("coinc_boundary", 32'({period_start, pending}), 32'b10);
    high = 0;
    for (int k = 0; k < 6; k++) begin step(); high += int'(pwm[0]); end
    check("coinc_b_high", 32'(high), 32'd5);

    // Reset mid-period discards a pending shadow
    do_reset();
    do_load(10, 8, 4'b0001, 4'b0000, 1'b0);
    wait_ps(50);
    step(); step(); step();
    do_load(10, 9, 4'b1111, 4'b0000, 1'b0);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("rst_mid_outputs", 32'({pending, period_start, pwm}), 32'd0);
    high = 0;
    for (int k = 0; k < 30; k++) begin step(); high += int'(pwm != '0); end
    check("rst_shadow_discarded", 32'(high), 32'd0);

    // Randomized traffic against the reference model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      resetn = ($urandom_range(0, 299) != 0);
      load = ($urandom_range(0, 9) == 0);
      if (load) begin
        period_in = CNT_W'($urandom_range(0, 12));
        for (int i = 0; i < NUM_CH; i++) duty_in[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 14));
        ch_en_in  = NUM_CH'($urandom);
        invert_in = NUM_CH'($urandom);
        center_in = 1'($urandom);
      end
      step();
    end
    load = 1'b0;
    resetn = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
